// File: rtl/fetch_pkg.sv
// Shared types for the fetch queue: one decoded-ready queue entry and the
// incoming fetch packet as presented by the aligner.
package fetch_pkg;

  localparam int ILEN          = 32;
  localparam int XLEN_P        = 32;
  localparam int FETCH_WIDTH_P = 2;
  localparam int DEPTH_P       = 8;
  localparam int LANE_OFF_W    = (FETCH_WIDTH_P <= 1) ? 1 : $clog2(FETCH_WIDTH_P);

  typedef struct packed {
    logic [ILEN-1:0]   instr;
    logic [XLEN_P-1:0] pc;
    logic              pred_taken;
    logic [XLEN_P-1:0] pred_target;
  } fetch_entry_t;

  typedef struct packed {
    logic [XLEN_P-1:0]             pc;
    logic [FETCH_WIDTH_P*ILEN-1:0] data;
    logic [FETCH_WIDTH_P-1:0]      mask;
    logic                          pred_taken;
    logic [XLEN_P-1:0]             pred_target;
  } fetch_packet_t;

endpackage

// File: rtl/fetch_lane_compact.sv
// Combinational lane compactor: assigns each valid lane a dense write slot
// and attaches PC and prediction metadata to it.
module fetch_lane_compact
  import fetch_pkg::*;
(
  input  fetch_packet_t             pkt,
  output logic [LANE_OFF_W-1:0]     slot_off   [FETCH_WIDTH_P],
  output logic [FETCH_WIDTH_P-1:0]  lane_we,
  output fetch_entry_t              lane_entry [FETCH_WIDTH_P],
  output logic [LANE_OFF_W:0]       n
);

  logic [LANE_OFF_W:0] run;
  logic                higher;

  always_comb begin
    run = '0;
    for (int i = 0; i < FETCH_WIDTH_P; i++) begin
      slot_off[i] = run[LANE_OFF_W-1:0];
      run = run + {{LANE_OFF_W{1'b0}}, pkt.mask[i]};
    end
    n = run;
  end

  // Walk lanes from the top so only the highest valid lane keeps the prediction.
  always_comb begin
    higher = 1'b0;
    for (int i = FETCH_WIDTH_P - 1; i >= 0; i--) begin
      lane_entry[i].instr       = pkt.data[ILEN*i +: ILEN];
      lane_entry[i].pc          = pkt.pc + XLEN_P'(4 * i);
      lane_entry[i].pred_taken  = pkt.pred_taken & pkt.mask[i] & ~higher;
      lane_entry[i].pred_target = (pkt.mask[i] && !higher) ? pkt.pred_target : '0;
      higher = higher | pkt.mask[i];
    end
  end

  assign lane_we = pkt.mask;

endmodule

// File: rtl/fetch_align_queue.sv
// Fetch-to-decode instruction queue: compacts fetch packet lanes into a
// circular buffer and delivers one instruction per cycle to decode.
module fetch_align_queue
  import fetch_pkg::*;
#(
  parameter int XLEN        = XLEN_P,
  parameter int FETCH_WIDTH = FETCH_WIDTH_P,
  parameter int DEPTH       = DEPTH_P
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      fe_valid,
  output logic                      fe_ready,
  input  logic [XLEN-1:0]           fe_pc,
  input  logic [FETCH_WIDTH*32-1:0] fe_data,
  input  logic [FETCH_WIDTH-1:0]    fe_mask,
  input  logic                      fe_pred_taken,
  input  logic [XLEN-1:0]           fe_pred_target,
  output logic                      de_valid,
  input  logic                      de_ready,
  output logic [31:0]               de_instr,
  output logic [XLEN-1:0]           de_pc,
  output logic                      de_pred_taken,
  output logic [XLEN-1:0]           de_pred_target,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_packet_t          pkt;
  logic [LANE_OFF_W-1:0]  lane_off   [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0] lane_we;
  fetch_entry_t           lane_entry [FETCH_WIDTH];
  logic [LANE_OFF_W:0]    lane_n;

  fetch_entry_t           mem_q [DEPTH];
  fetch_entry_t           head_entry;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          enq;
  logic          deq;

  assign pkt = '{pc: fe_pc, data: fe_data, mask: fe_mask,
                 pred_taken: fe_pred_taken, pred_target: fe_pred_target};

  fetch_lane_compact u_compact (
    .pkt        (pkt),
    .slot_off   (lane_off),
    .lane_we    (lane_we),
    .lane_entry (lane_entry),
    .n          (lane_n)
  );

  // Readiness depends only on registered occupancy and flush, never on fe_valid/de_ready.
  assign fe_ready = (count_q <= CW'(DEPTH - FETCH_WIDTH)) && !flush;
  assign de_valid = (count_q != '0);
  assign enq      = fe_valid && fe_ready;
  assign deq      = de_valid && de_ready && !flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (deq) head_d = head_q + PW'(1);
      if (enq) tail_d = tail_q + PW'(lane_n);
      count_d = count_q + (enq ? CW'(lane_n) : CW'(0)) - (deq ? CW'(1) : CW'(0));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (enq && lane_we[i]) begin
        mem_q[tail_q + PW'(lane_off[i])] <= lane_entry[i];
      end
    end
  end

  assign head_entry = mem_q[head_q];

  always_comb begin
    de_instr       = '0;
    de_pc          = '0;
    de_pred_taken  = 1'b0;
    de_pred_target = '0;
    if (de_valid) begin
      de_instr       = head_entry.instr;
      de_pc          = head_entry.pc;
      de_pred_taken  = head_entry.pred_taken;
      de_pred_target = head_entry.pred_target;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_fetch_align_queue.sv
// Scoreboard bench for fetch_align_queue: stimulus drives packets, a negedge
// monitor models occupancy and checks every delivered instruction.
module tb_fetch_align_queue;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        fe_valid = 1'b0;
  logic        fe_ready;
  logic [31:0] fe_pc = '0;
  logic [63:0] fe_data = '0;
  logic [1:0]  fe_mask = '0;
  logic        fe_pred_taken = 1'b0;
  logic [31:0] fe_pred_target = '0;
  logic        de_valid;
  logic        de_ready = 1'b0;
  logic [31:0] de_instr;
  logic [31:0] de_pc;
  logic        de_pred_taken;
  logic [31:0] de_pred_target;
  logic [3:0]  count;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   mcount = 0;
  bit   t4_done;

  fetch_align_queue dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .fe_valid       (fe_valid),
    .fe_ready       (fe_ready),
    .fe_pc          (fe_pc),
    .fe_data        (fe_data),
    .fe_mask        (fe_mask),
    .fe_pred_taken  (fe_pred_taken),
    .fe_pred_target (fe_pred_target),
    .de_valid       (de_valid),
    .de_ready       (de_ready),
    .de_instr       (de_instr),
    .de_pc          (de_pc),
    .de_pred_taken  (de_pred_taken),
    .de_pred_target (de_pred_target),
    .count          (count)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Monitor / scoreboard: model occupancy, pop before push so no bypass is assumed.
  always @(negedge clk) begin
    exp_t e;
    logic exp_ready;
    int   n;
    if (rst) begin
      sb.delete();
      mcount = 0;
    end else begin
      exp_ready = (8 - mcount >= 2) && !flush;
      chk("fe_ready", {31'd0, fe_ready}, {31'd0, exp_ready});
      chk("count", {28'd0, count}, mcount);
      chk("de_valid", {31'd0, de_valid}, (mcount != 0) ? 32'd1 : 32'd0);
      if (mcount == 0) chk("de_instr_empty", de_instr, 32'd0);
      if (mcount != 0 && de_ready && !flush) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: dequeue of pc %0h with no expected entry", de_pc);
        end else begin
          e = sb.pop_front();
          chk("de_instr", de_instr, e.instr);
          chk("de_pc", de_pc, e.pc);
          chk("de_pred_taken", {31'd0, de_pred_taken}, {31'd0, e.taken});
          chk("de_pred_target", de_pred_target, e.tgt);
          $display("deq instr=%h pc=%h taken=%0d target=%h", de_instr, de_pc, de_pred_taken, de_pred_target);
        end
        mcount--;
      end
      n = 0;
      if (fe_valid && exp_ready) begin
        for (int i = 0; i < 2; i++) begin
          if (fe_mask[i]) begin
            logic last;
            last    = (i == 1) || !fe_mask[1];
            e.instr = fe_data[32*i +: 32];
            e.pc    = fe_pc + 32'(4 * i);
            e.taken = fe_pred_taken && last;
            e.tgt   = last ? fe_pred_target : 32'd0;
            sb.push_back(e);
            n++;
          end
        end
      end
      mcount += n;
      if (flush) begin
        sb.delete();
        mcount = 0;
      end
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] pc, input logic [63:0] data, input logic [1:0] mask,
                      input logic pt, input logic [31:0] tgt);
    int   waitc = 0;
    logic acc = 1'b0;
    fe_valid = 1'b1; fe_pc = pc; fe_data = data; fe_mask = mask;
    fe_pred_taken = pt; fe_pred_target = tgt;
    while (!acc) begin
      @(negedge clk);
      acc = fe_ready;
      @(posedge clk);
      #1;
      if (!acc) begin
        waitc++;
        if (waitc > 200) begin
          checks++;
          errors++;
          $display("FAIL send_timeout: pc %0h not accepted within 200 cycles", pc);
          acc = 1'b1;
        end
      end
    end
    fe_valid = 1'b0;
  endtask

  function automatic logic [63:0] full(input logic [31:0] pc);
    return {(pc + 32'd4) ^ 32'h0000_0013, pc ^ 32'h0000_0013};
  endfunction

  task automatic neg_chk(string name, logic [31:0] act_sel, logic [31:0] exp);
    chk(name, act_sel, exp);
  endtask

  initial begin
    #2;
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_de_valid", {31'd0, de_valid}, 32'd0);
    chk("rst_de_instr", de_instr, 32'd0);
    chk("rst_de_pc", de_pc, 32'd0);
    cyc(2);
    rst = 1'b0;

    // Single full packet
    de_ready = 1'b1;
    send(32'h100, {32'h00A00093, 32'h00500113}, 2'b11, 1'b0, 32'h0);
    cyc(4);
    @(negedge clk);
    chk("t1_drained", sb.size(), 32'd0);
    cyc(1);

    // Sparse masks with prediction, and an empty mask
    de_ready = 1'b0;
    send(32'h200, {32'h11111111, 32'h22222222}, 2'b10, 1'b1, 32'h400);
    @(negedge clk);
    chk("t2_count", {28'd0, count}, 32'd1);
    cyc(1);
    de_ready = 1'b1;
    send(32'h300, {32'h33333333, 32'h44444444}, 2'b01, 1'b1, 32'h600);
    send(32'h308, {32'h55555555, 32'h66666666}, 2'b00, 1'b1, 32'h700);
    cyc(4);

    // Fill to full, then hold a fifth packet until two entries drain
    de_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(32'h1000 + 32'(8 * k), full(32'h1000 + 32'(8 * k)), 2'b11, 1'b0, 32'h0);
    @(negedge clk);
    chk("t3_full_count", {28'd0, count}, 32'd8);
    chk("t3_full_ready", {31'd0, fe_ready}, 32'd0);
    cyc(1);
    fork
      begin de_ready = 1'b1; cyc(2); de_ready = 1'b0; end
      send(32'h1020, full(32'h1020), 2'b11, 1'b1, 32'h9000);
    join
    @(negedge clk);
    chk("t3_refill_count", {28'd0, count}, 32'd8);
    cyc(1);
    de_ready = 1'b1;
    cyc(12);

    // Streaming with wrap-around and random decode stalls
    t4_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 20; k++) send(32'h2000 + 32'(8 * k), full(32'h2000 + 32'(8 * k)), 2'b11, 1'b0, 32'h0);
        t4_done = 1'b1;
      end
      begin
        while (!t4_done) begin de_ready = 1'($urandom_range(0, 1)); cyc(1); end
      end
    join
    de_ready = 1'b1;
    cyc(45);
    @(negedge clk);
    chk("t4_drained", sb.size(), 32'd0);
    chk("t4_count", {28'd0, count}, 32'd0);
    cyc(1);

    // Flush with simultaneous enqueue and dequeue attempt
    de_ready = 1'b0;
    send(32'h5000, full(32'h5000), 2'b11, 1'b0, 32'h0);
    send(32'h5008, full(32'h5008), 2'b11, 1'b0, 32'h0);
    send(32'h5010, full(32'h5010), 2'b01, 1'b0, 32'h0);
    @(negedge clk);
    chk("t5_count", {28'd0, count}, 32'd5);
    cyc(1);
    flush = 1'b1; fe_valid = 1'b1; fe_pc = 32'h6000; fe_data = full(32'h6000); fe_mask = 2'b11; de_ready = 1'b1;
    @(negedge clk);
    chk("t5_flush_ready", {31'd0, fe_ready}, 32'd0);
    cyc(1);
    flush = 1'b0; fe_valid = 1'b0;
    @(negedge clk);
    chk("t5_post_count", {28'd0, count}, 32'd0);
    chk("t5_post_valid", {31'd0, de_valid}, 32'd0);
    cyc(5);

    // Asynchronous reset between edges
    de_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(32'h7000 + 32'(8 * k), full(32'h7000 + 32'(8 * k)), 2'b11, 1'b0, 32'h0);
    @(negedge clk);
    chk("t6_count", {28'd0, count}, 32'd6);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t6_async_count", {28'd0, count}, 32'd0);
    chk("t6_async_valid", {31'd0, de_valid}, 32'd0);
    cyc(1);
    rst = 1'b0;
    de_ready = 1'b1;
    send(32'h8000, full(32'h8000), 2'b11, 1'b1, 32'h8800);
    cyc(5);
    @(negedge clk);
    chk("t6_drained", sb.size(), 32'd0);
    chk("t6_final_count", {28'd0, count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, got no finish, expected finish before 100000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_align_queue.md
Name: fetch_align_queue

Overview:
Instruction fetch queue between the fetch stage (ICache data plus aligner output) and decode. It accepts one fetch packet per cycle and compacts that packet's valid 32-bit lanes into a circular buffer. It delivers one instruction per cycle to decode, with its PC and prediction metadata, under valid/ready. It decouples fetch stalls from decode stalls and discards all contents on a pipeline redirect (flush).

Parameters:
XLEN, 32, address/PC width
FETCH_WIDTH, 2, 32-bit instruction lanes per fetch packet (power of two)
DEPTH, 8, queue entries (power of two, >= 2*FETCH_WIDTH)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  redirect; discard all queue contents
fe_valid  in  1  fetch packet valid
fe_ready  out  1  queue can accept a full packet this cycle
fe_pc  in  XLEN  PC of lane 0, aligned to FETCH_WIDTH*4
fe_data  in  FETCH_WIDTH*32  lane i at bits [32*i+31:32*i]
fe_mask  in  FETCH_WIDTH  per-lane valid
fe_pred_taken  in  1  packet ends in a predicted-taken branch
fe_pred_target  in  XLEN  predicted target
de_valid  out  1  head entry valid
de_ready  in  1  decode accepts head
de_instr  out  32  head instruction
de_pc  out  XLEN  head PC
de_pred_taken  out  1  head predicted taken
de_pred_target  out  XLEN  head predicted target
count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (async, rst=1): head=0, tail=0, count=0. All de_* outputs read 0. Storage array is not reset.
- fe_ready = (DEPTH - count >= FETCH_WIDTH) && !flush. It is derived only from registered state and flush, so there is no combinational path from fe_valid or de_ready.
- Enqueue fires when fe_valid && fe_ready.
  - Valid lanes are written in ascending lane order to tail, tail+1, and so on, with gaps compacted.
  - n = popcount(fe_mask); tail advances by n modulo DEPTH.
  - PC of lane i = fe_pc + 4*i.
  - pred_taken/pred_target go only to the highest-index valid lane; all other lanes get pred_taken=0 and pred_target=0.
  - fe_mask=0 is accepted with no state change.
- Dequeue fires when de_valid && de_ready. Head advances by 1 modulo DEPTH.
- de_valid = (count != 0). de_* come combinationally from the head entry and are forced to 0 when empty.
- Enqueue and dequeue in the same cycle: count_next = count + n - 1.
- No bypass: a packet enqueued in cycle T is visible at de_* in cycle T+1 at the earliest.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH; fe_ready guarantees this.
- Flush has priority over everything:
  - Next cycle head=tail=count=0.
  - Any enqueue or dequeue in the flush cycle is ignored; fe_ready=0 in that cycle.
  - de_valid may still be 1 in the flush cycle; decode must ignore it.
- Reset asserted mid-operation clears state immediately and asynchronously. Lost in-flight packets are acceptable.
- Holding contract: while de_valid && !de_ready, de_* hold stable. While fe_valid && !fe_ready, the upstream holds the packet.

Decomposition:
- Shared package fetch_pkg:
  - ILEN=32.
  - typedef fetch_entry_t {instr[31:0], pc[XLEN-1:0], pred_taken, pred_target[XLEN-1:0]}.
  - typedef fetch_packet_t mirroring the fe_* fields.
- One combinational sub-module, fetch_lane_compact: inputs fe_mask plus packet fields. It outputs, per lane, a compacted write-slot offset (prefix popcount), a write-enable, an fetch_entry_t with PC and prediction attached, and the total n.
- The queue module handles pointers, count, storage and flush.

Test Plan:
1. Reset then a single packet: fe_pc=0x100, data={0x00A00093 (lane1), 0x00500113 (lane0)}, mask=2'b11, de_ready=1. Expected: de_valid rises the next cycle; de_instr=0x00500113, de_pc=0x100; then 0x00A00093, de_pc=0x104; then count=0.
2. Sparse mask with prediction: mask=2'b10, fe_pc=0x200, pred_taken=1, target=0x400. Expected: exactly one entry with de_pc=0x204, pred_taken=1, pred_target=0x400, count=1.
3. Fill to full: de_ready=0, four full packets. Expected: count=8, fe_ready=0 after the 4th; a 5th packet is held. Raise de_ready for 2 cycles → fe_ready=1 and the 5th packet is enqueued.
4. Wrap-around: stream 20 full packets with de_ready toggling pseudo-randomly. Expected: the output PC sequence is strictly +4 with no loss or duplication, checked against a scoreboard.
5. Flush with simultaneous enq/deq: count=5, assert flush with fe_valid=1 and de_ready=1. Expected: fe_ready=0 that cycle; the next cycle count=0, de_valid=0; the flushed-cycle packet is never delivered.
6. Async reset mid-stream: assert rst between clock edges with count=6. Expected: count=0 and de_valid=0 immediately, before the next edge; normal operation after deassertion.
